// File: rtl/tlm_collect_pkg.sv
// Shared types and helpers for the TLM result collector: bank/writer state
// encodings and the constant log2 used to size count fields.
package tlm_collect_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    typedef enum logic {
        WR_RUN   = 1'b0,
        WR_STALL = 1'b1
    } wr_state_e;

    // Ceiling log2, usable in constant expressions (port widths).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tlm_collect_bank.sv
// One ping-pong bank: NUM result slots, a write port, and an
// EMPTY -> FILLING -> FULL -> EMPTY lifecycle driven by close/free.
module tlm_collect_bank
    import tlm_collect_pkg::*;
#(
    parameter int NUM       = 100,
    parameter int RES_WIDTH = 8,
    parameter int CNT_W     = 7
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     we_i,
    input  logic [CNT_W-1:0]         idx_i,
    input  logic [RES_WIDTH-1:0]     wdata_i,
    input  logic                     close_i,
    input  logic [CNT_W-1:0]         close_len_i,
    input  logic                     free_i,
    output bank_state_e              state_o,
    output logic [CNT_W-1:0]         len_o,
    output logic [NUM*RES_WIDTH-1:0] data_o
);

    bank_state_e      state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;

    // Free wins over close; the top never frees and closes the same bank at once.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        if (free_i) begin
            state_d = BANK_EMPTY;
            len_d   = '0;
        end else if (close_i) begin
            state_d = BANK_FULL;
            len_d   = close_len_i;
        end else if (we_i && (state_q == BANK_EMPTY)) begin
            state_d = BANK_FILLING;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= BANK_EMPTY;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    for (genvar gi = 0; gi < NUM; gi++) begin : g_item
        logic [RES_WIDTH-1:0] item_q;

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                item_q <= '0;
            end else if (we_i && (idx_i == CNT_W'(gi))) begin
                item_q <= wdata_i;
            end
        end

        assign data_o[gi*RES_WIDTH +: RES_WIDTH] = item_q;
    end

    assign state_o = state_q;
    assign len_o   = len_q;

endmodule

// File: rtl/tlm_result_collector.sv
// Packs BFM result beats into NUM-item batches across two ping-pong banks
// and presents completed banks to the host with a valid/ack handshake.
module tlm_result_collector
    import tlm_collect_pkg::*;
#(
    parameter int  NUM       = 100,
    parameter int  RES_WIDTH = 8,
    localparam int CNT_W     = clog2(NUM + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [RES_WIDTH-1:0]     res_i,
    input  logic                     res_valid_i,
    output logic                     res_ready_o,
    input  logic                     flush_i,
    output logic                     batch_valid_o,
    output logic [NUM*RES_WIDTH-1:0] batch_data_o,
    output logic [CNT_W-1:0]         batch_len_o,
    input  logic                     batch_ack_i,
    output logic [15:0]              drop_cnt_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM - 1);

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] count_q, count_d;
    wr_state_e        wr_state_q, wr_state_d;
    logic [15:0]      drop_q, drop_d;

    bank_state_e              bank_state [2];
    logic [CNT_W-1:0]         bank_len   [2];
    logic [NUM*RES_WIDTH-1:0] bank_data  [2];

    logic             accept;
    logic             ack_fire;
    logic             close_batch;
    logic             other_free;
    logic             stall_release;
    logic [CNT_W-1:0] fill_len;

    assign res_ready_o   = (wr_state_q == WR_RUN);
    assign batch_valid_o = (bank_state[rd_bank_q] == BANK_FULL);
    assign batch_data_o  = batch_valid_o ? bank_data[rd_bank_q] : '0;
    assign batch_len_o   = batch_valid_o ? bank_len[rd_bank_q] : '0;
    assign drop_cnt_o    = drop_q;

    assign accept   = res_valid_i & res_ready_o;
    assign ack_fire = batch_ack_i & batch_valid_o;
    assign fill_len = count_q + {{(CNT_W-1){1'b0}}, accept};

    // A flush closes the batch including any beat accepted in the same cycle.
    assign close_batch = (accept && (count_q == LAST_IDX)) ||
                         (flush_i && (fill_len != '0));

    // A bank being acked at this edge counts as free for the writer.
    assign other_free    = (bank_state[~wr_bank_q] == BANK_EMPTY) ||
                           (ack_fire && (rd_bank_q != wr_bank_q));
    assign stall_release = (bank_state[wr_bank_q] == BANK_EMPTY) ||
                           (ack_fire && (rd_bank_q == wr_bank_q));

    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        count_d    = count_q;
        rd_bank_d  = rd_bank_q ^ ack_fire;
        drop_d     = drop_q;
        unique case (wr_state_q)
            WR_RUN: begin
                if (close_batch) begin
                    count_d   = '0;
                    wr_bank_d = ~wr_bank_q;
                    if (!other_free) begin
                        wr_state_d = WR_STALL;
                    end
                end else if (accept) begin
                    count_d = fill_len;
                end
            end
            WR_STALL: begin
                if (stall_release) begin
                    wr_state_d = WR_RUN;
                end
            end
            default: wr_state_d = WR_RUN;
        endcase
        if (res_valid_i && !res_ready_o && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_state_q <= WR_RUN;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            count_q    <= '0;
            drop_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        tlm_collect_bank #(
            .NUM       (NUM),
            .RES_WIDTH (RES_WIDTH),
            .CNT_W     (CNT_W)
        ) u_bank (
            .clk_i       (clk_i),
            .reset_ni    (reset_ni),
            .we_i        (accept && (wr_bank_q == 1'(gi))),
            .idx_i       (count_q),
            .wdata_i     (res_i),
            .close_i     (close_batch && (wr_bank_q == 1'(gi))),
            .close_len_i (fill_len),
            .free_i      (ack_fire && (rd_bank_q == 1'(gi))),
            .state_o     (bank_state[gi]),
            .len_o       (bank_len[gi]),
            .data_o      (bank_data[gi])
        );
    end

endmodule

// File: tb/tb_tlm_result_collector.sv
// Self-checking bench for tlm_result_collector with NUM=4, RES_WIDTH=8:
// table-driven single batches plus hand-written stall/ack/reset sequences.
module tb_tlm_result_collector;

    localparam int NUM   = 4;
    localparam int RW    = 8;
    localparam int CNT_W = 3;

    logic                clk_i = 1'b0;
    logic                reset_ni = 1'b0;
    logic [RW-1:0]       res_i = '0;
    logic                res_valid_i = 1'b0;
    logic                res_ready_o;
    logic                flush_i = 1'b0;
    logic                batch_valid_o;
    logic [NUM*RW-1:0]   batch_data_o;
    logic [CNT_W-1:0]    batch_len_o;
    logic                batch_ack_i = 1'b0;
    logic [15:0]         drop_cnt_o;

    tlm_result_collector #(.NUM(NUM), .RES_WIDTH(RW)) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .res_i         (res_i),
        .res_valid_i   (res_valid_i),
        .res_ready_o   (res_ready_o),
        .flush_i       (flush_i),
        .batch_valid_o (batch_valid_o),
        .batch_data_o  (batch_data_o),
        .batch_len_o   (batch_len_o),
        .batch_ack_i   (batch_ack_i),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          len;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2, b3;
        bit         flush_last;
        bit         flush_after;
        int         exp_len;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [7:0] v, input bit with_flush);
        res_i       = v;
        res_valid_i = 1'b1;
        flush_i     = with_flush;
        tick();
        res_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input int l);
        exp_t e;
        e.data = d;
        e.len  = l;
        sb.push_back(e);
    endtask

    // Compares the presented bank against the oldest expected batch.
    task automatic present(input string name);
        exp_t        e;
        logic [31:0] m;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got valid=%0b", name, batch_valid_o);
        end else begin
            e = sb.pop_front();
            m = (e.len >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * e.len)) - 32'h1);
            $display("batch %s: valid=%0b len=%0d data=%h", name, batch_valid_o, batch_len_o, batch_data_o);
            chk({name, "_valid"}, 64'(batch_valid_o), 64'd1);
            chk({name, "_len"}, 64'(batch_len_o), 64'(e.len));
            chk({name, "_data"}, 64'(batch_data_o & m), 64'(e.data & m));
        end
    endtask

    task automatic ack();
        batch_ack_i = 1'b1;
        tick();
        batch_ack_i = 1'b0;
    endtask

    initial begin
        logic [7:0] bb[4];

        vecs[0] = '{4, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 4, 32'h44332211};
        vecs[1] = '{2, 8'h05, 8'h06, 8'h00, 8'h00, 1'b0, 1'b1, 2, 32'h00000605};
        vecs[2] = '{3, 8'h07, 8'h08, 8'h09, 8'h00, 1'b1, 1'b0, 3, 32'h00090807};
        vecs[3] = '{1, 8'hAB, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1, 32'h000000AB};

        // Reset state
        repeat (2) @(posedge clk_i);
        #3;
        chk("rst_ready", 64'(res_ready_o), 64'd1);
        chk("rst_valid", 64'(batch_valid_o), 64'd0);
        chk("rst_len", 64'(batch_len_o), 64'd0);
        chk("rst_data", 64'(batch_data_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        reset_ni = 1'b1;
        tick();

        // Table-driven single batches, each acked before the next
        for (int i = 0; i < 4; i++) begin
            bb[0] = vecs[i].b0; bb[1] = vecs[i].b1; bb[2] = vecs[i].b2; bb[3] = vecs[i].b3;
            for (int j = 0; j < vecs[i].n; j++) begin
                beat(bb[j], vecs[i].flush_last && (j == vecs[i].n - 1));
            end
            if (vecs[i].flush_after) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
            end
            push_exp(vecs[i].exp_data, vecs[i].exp_len);
            present($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ready", i), 64'(res_ready_o), 64'd1);
            ack();
            chk($sformatf("vec%0d_valid_after_ack", i), 64'(batch_valid_o), 64'd0);
        end

        // Flush with nothing captured, then ack with nothing presented
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_empty_valid", 64'(batch_valid_o), 64'd0);
        chk("flush_empty_ready", 64'(res_ready_o), 64'd1);
        ack();
        chk("ack_idle_valid", 64'(batch_valid_o), 64'd0);

        // Two full banks without ack -> stall, drop, then release by ack
        for (int j = 1; j <= 8; j++) begin
            beat(8'(j), 1'b0);
            if (j == 4) begin
                push_exp(32'h04030201, 4);
                chk("stall_b4_valid", 64'(batch_valid_o), 64'd1);
                chk("stall_b4_ready", 64'(res_ready_o), 64'd1);
            end
        end
        push_exp(32'h08070605, 4);
        chk("stall_ready", 64'(res_ready_o), 64'd0);
        beat(8'h09, 1'b0);
        chk("stall_drop", 64'(drop_cnt_o), 64'd1);
        chk("stall_ready_held", 64'(res_ready_o), 64'd0);
        present("stall_bank0");
        ack();
        chk("stall_release_ready", 64'(res_ready_o), 64'd1);
        present("stall_bank1");
        ack();
        chk("stall_drained_valid", 64'(batch_valid_o), 64'd0);

        // Ack coincides with the completing beat of the second bank
        for (int j = 0; j < 4; j++) beat(8'h20 + 8'(j), 1'b0);
        push_exp(32'h23222120, 4);
        present("simul_first");
        for (int j = 0; j < 3; j++) begin
            beat(8'h30 + 8'(j), 1'b0);
            chk($sformatf("simul_ready%0d", j), 64'(res_ready_o), 64'd1);
        end
        batch_ack_i = 1'b1;
        beat(8'h33, 1'b0);
        batch_ack_i = 1'b0;
        push_exp(32'h33323130, 4);
        chk("simul_ready_after", 64'(res_ready_o), 64'd1);
        present("simul_second");
        ack();
        chk("simul_drained", 64'(batch_valid_o), 64'd0);

        // Held ack frees exactly one bank per presentation
        for (int j = 0; j < 8; j++) beat(8'h40 + 8'(j), 1'b0);
        push_exp(32'h43424140, 4);
        push_exp(32'h47464544, 4);
        present("held_first");
        batch_ack_i = 1'b1;
        tick();
        present("held_second");
        tick();
        chk("held_valid1", 64'(batch_valid_o), 64'd0);
        tick();
        chk("held_valid2", 64'(batch_valid_o), 64'd0);
        batch_ack_i = 1'b0;
        for (int j = 0; j < 4; j++) beat(8'h50 + 8'(j), 1'b0);
        push_exp(32'h53525150, 4);
        present("held_after");

        // Async reset mid-fill with a bank presented
        beat(8'h61, 1'b0);
        beat(8'h62, 1'b0);
        #2;
        reset_ni = 1'b0;
        #1;
        sb.delete();
        chk("arst_valid", 64'(batch_valid_o), 64'd0);
        chk("arst_len", 64'(batch_len_o), 64'd0);
        chk("arst_data", 64'(batch_data_o), 64'd0);
        chk("arst_ready", 64'(res_ready_o), 64'd1);
        chk("arst_drop", 64'(drop_cnt_o), 64'd0);
        tick();
        #3;
        reset_ni = 1'b1;
        tick();
        beat(8'hA1, 1'b1);
        push_exp(32'h000000A1, 1);
        chk("arst_full_data", 64'(batch_data_o), 64'h000000A1);
        present("arst_first");
        ack();
        chk("arst_drained", 64'(batch_valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
